// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared definitions for the multi-port register file: default
//               geometry constants and the clear/run state type that the
//               pipeline-stall logic also uses to interpret ready.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int unsigned RF_REG_W  = 5;
    localparam int unsigned RF_REG_S  = 32;
    localparam int unsigned RF_DATA_W = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : rf_clear_seq
// Description : Reset-triggered clear sequencer. After reset releases it walks
//               the clear index from 0 to REG_S-1, one entry per cycle, then
//               parks in RUN and raises ready.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clr_we        - zero the entry at clr_addr this cycle
//               clr_addr      - entry being cleared
//               ready         - registered; high once every entry is cleared
// Revision    : 1.0 - initial release
// ============================================================================
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int unsigned REG_W = RF_REG_W,
    parameter int unsigned REG_S = RF_REG_S
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clr_we,
    output logic [REG_W-1:0] clr_addr,
    output logic             ready
);

    localparam logic [REG_W-1:0] C_LAST = REG_W'(REG_S - 1);

    rf_state_e        state_q, state_d;
    logic [REG_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = ~rst;
                if (cnt_q == C_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + REG_W'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
        // ready tracks the state register so it rises on the same edge that
        // the last entry is cleared.
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign clr_addr = cnt_q;
    assign ready    = ready_q;

endmodule : rf_clear_seq
`default_nettype wire

// File: rtl/rfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : rfile_mp
// Description : Register file with NR combinational read ports, two write
//               ports (port 1 has priority), optional same-cycle write-to-read
//               bypass, entry 0 hardwired to zero, and a clear sequencer that
//               zeroes the array after reset.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               ra / rd             - packed read addresses / read data
//               we0, wa0, wd0       - write port 0 (ALU writeback)
//               we1, wa1, wd1       - write port 1 (load writeback, wins ties)
//               ready               - clear finished, writes accepted
// Revision    : 1.0 - initial release
// ============================================================================
module rfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned REG_W  = RF_REG_W,
    parameter int unsigned REG_S  = RF_REG_S,
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned NR     = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR*REG_W-1:0]  ra,
    output logic [NR*DATA_W-1:0] rd,
    input  logic                 we0,
    input  logic [REG_W-1:0]     wa0,
    input  logic [DATA_W-1:0]    wd0,
    input  logic                 we1,
    input  logic [REG_W-1:0]     wa1,
    input  logic [DATA_W-1:0]    wd1,
    output logic                 ready
);

    logic             w_clr_we;
    logic [REG_W-1:0] w_clr_addr;
    logic             w_run;
    logic             w_wr_en;

    rf_clear_seq #(
        .REG_W (REG_W),
        .REG_S (REG_S)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .ready    (w_run)
    );

    assign ready   = w_run;
    // ready is high exactly while the sequencer is in RUN.
    assign w_wr_en = w_run & ~rst;

    logic [DATA_W-1:0] rf_q [REG_S];
    logic [DATA_W-1:0] rf_d [REG_S];

    // Per-entry address decode: addresses outside 1..REG_S-1 match no entry,
    // so out-of-range and x0 writes fall away without any wrap.
    always_comb begin
        rf_d[0] = '0;
        for (int unsigned e = 1; e < REG_S; e++) begin
            rf_d[e] = rf_q[e];
            if (w_clr_we) begin
                if (32'(w_clr_addr) == e) begin
                    rf_d[e] = '0;
                end
            end else if (w_wr_en) begin
                if (we0 && (32'(wa0) == e)) begin
                    rf_d[e] = wd0;
                end
                // Later assignment gives port 1 the priority on collisions.
                if (we1 && (32'(wa1) == e)) begin
                    rf_d[e] = wd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    for (genvar p = 0; p < int'(NR); p++) begin : g_rd
        logic [REG_W-1:0]  w_ra;
        logic [DATA_W-1:0] w_val;
        logic              w_hit;

        assign w_ra = ra[p*REG_W +: REG_W];

        always_comb begin
            w_val = '0;
            w_hit = (w_ra != '0) && (32'(w_ra) < REG_S);
            for (int unsigned e = 1; e < REG_S; e++) begin
                if (32'(w_ra) == e) begin
                    w_val = rf_q[e];
                end
            end
            if (BYPASS && w_run && w_hit) begin
                if (we1 && (wa1 == w_ra)) begin
                    w_val = wd1;
                end else if (we0 && (wa0 == w_ra)) begin
                    w_val = wd0;
                end
            end
        end

        assign rd[p*DATA_W +: DATA_W] = w_val;
    end : g_rd

endmodule : rfile_mp
`default_nettype wire

// File: tb/tb_rfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfile_mp
// Description : Self-checking bench for rfile_mp. Two instances share the same
//               stimulus: cfg 0 = 32 entries with bypass, cfg 1 = 16 entries
//               without bypass (5-bit addresses reach past the array).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  ra  = '0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  wa0 = '0,   wa1 = '0;
    logic [31:0] wd0 = '0,   wd1 = '0;
    logic [63:0] rd_a, rd_b;
    logic        rdy_a, rdy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rfile_mp #(.REG_W(5), .REG_S(32), .DATA_W(32), .NR(2), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_a),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ready(rdy_a)
    );

    rfile_mp #(.REG_W(5), .REG_S(16), .DATA_W(32), .NR(2), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ready(rdy_b)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m     [2][32];
    bit          known [2][32];
    int          clr   [2];
    bit          have_reset = 1'b0;

    function automatic int sz(input int c);
        return (c == 0) ? 32 : 16;
    endfunction

    function automatic bit byp(input int c);
        return c == 0;
    endfunction

    // {known, data} that read address a must return right now
    function automatic logic [32:0] model_rd(input int c, input int a);
        if (a == 0 || a >= sz(c)) return {1'b1, 32'h0};
        if (byp(c) && clr[c] == sz(c)) begin
            if (we1 && int'(wa1) == a) return {1'b1, wd1};
            if (we0 && int'(wa0) == a) return {1'b1, wd0};
        end
        return {known[c][a], m[c][a]};
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                clr[c] = 0;
            end else if (clr[c] < sz(c)) begin
                m[c][clr[c]]     = 32'h0;
                known[c][clr[c]] = 1'b1;
                clr[c]++;
            end else begin
                if (we0 && wa0 != 0 && int'(wa0) < sz(c)) m[c][wa0] = wd0;
                if (we1 && wa1 != 0 && int'(wa1) < sz(c)) m[c][wa1] = wd1;
            end
        end
        if (rst) have_reset = 1'b1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (have_reset) begin
            for (int c = 0; c < 2; c++) begin
                logic [63:0] rdv;
                logic        rdy;
                rdv = (c == 0) ? rd_a : rd_b;
                rdy = (c == 0) ? rdy_a : rdy_b;
                check($sformatf("ready cfg%0d", c), {63'd0, rdy}, {63'd0, clr[c] == sz(c)});
                for (int p = 0; p < 2; p++) begin
                    logic [32:0] e;
                    e = model_rd(c, int'(ra[p*5 +: 5]));
                    if (e[32])
                        check($sformatf("rd cfg%0d port%0d addr%0d", c, p, ra[p*5 +: 5]),
                              {32'd0, rdv[p*32 +: 32]}, {32'd0, e[31:0]});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
    endtask

    // Counts edges after rst drops until each instance raises ready; writes
    // held by the caller are dropped after 14 edges so none land in RUN.
    task automatic wait_ready(input int exp_a, input int exp_b, input string tag);
        int na = 0;
        int nb = 0;
        for (int n = 1; n <= 48; n++) begin
            tick();
            if (rdy_a && na == 0) na = n;
            if (rdy_b && nb == 0) nb = n;
            if (n == 14) idle();
            if (na != 0 && nb != 0) break;
        end
        idle();
        check({tag, " ready latency cfg0"}, 64'(na), 64'(exp_a));
        check({tag, " ready latency cfg1"}, 64'(nb), 64'(exp_b));
    endtask

    initial begin
        // Reset then clear
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        wait_ready(32, 16, "clear");
        set_ra(5'd1, 5'd31);
        @(negedge clk);
        check("x1 after clear cfg0", {32'd0, rd_a[31:0]},  64'h0);
        check("x31 after clear cfg0", {32'd0, rd_a[63:32]}, 64'h0);
        check("x1 after clear cfg1", {32'd0, rd_b[31:0]},  64'h0);
        tick();

        // Basic write / read
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; set_ra(5'd5, 5'd0);
        @(negedge clk);
        check("same-cycle no-bypass", {32'd0, rd_b[31:0]}, 64'h0);
        check("same-cycle bypass p0", {32'd0, rd_a[31:0]}, 64'hDEADBEEF);
        tick(); idle();
        @(negedge clk);
        check("read after write", {32'd0, rd_b[31:0]}, 64'hDEADBEEF);
        tick();

        // Collision and x0
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22;
        tick(); idle(); set_ra(5'd7, 5'd7);
        @(negedge clk);
        check("collision cfg0", {32'd0, rd_a[31:0]}, 64'h22);
        check("collision cfg1", {32'd0, rd_b[63:32]}, 64'h22);
        tick();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; set_ra(5'd0, 5'd0);
        @(negedge clk);
        check("x0 no bypass", {32'd0, rd_a[31:0]}, 64'h0);
        tick(); idle();
        @(negedge clk);
        check("x0 stays zero", {32'd0, rd_b[63:32]}, 64'h0);
        tick();

        // Bypass priority
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hA5A5A5A5;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1; set_ra(5'd0, 5'd3);
        @(negedge clk);
        check("bypass port1 wins", {32'd0, rd_a[63:32]}, 64'hA5A5A5A5);
        check("no-bypass stale",   {32'd0, rd_b[63:32]}, 64'h0);
        tick(); idle();
        @(negedge clk);
        check("stored port1 wins", {32'd0, rd_b[63:32]}, 64'hA5A5A5A5);
        tick();

        // Out of range on the 16-entry instance
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44;
        tick();
        wa0 = 5'd20; wd0 = 32'hCAFE0000; set_ra(5'd20, 5'd4);
        tick(); idle();
        @(negedge clk);
        check("oor read cfg1", {32'd0, rd_b[31:0]},  64'h0);
        check("x4 kept cfg1",  {32'd0, rd_b[63:32]}, 64'h44);
        check("x20 in range cfg0", {32'd0, rd_a[31:0]}, 64'hCAFE0000);
        tick();

        // Reset mid-operation
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234;
        tick(); idle(); set_ra(5'd9, 5'd2);
        @(negedge clk);
        check("x9 written", {32'd0, rd_b[31:0]}, 64'h1234);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hBAD0; we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hBAD1;
        repeat (10) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        wait_ready(32, 16, "restart");
        @(negedge clk);
        check("x9 cleared cfg0", {32'd0, rd_a[31:0]},  64'h0);
        check("x2 untouched cfg0", {32'd0, rd_a[63:32]}, 64'h0);
        check("x9 cleared cfg1", {32'd0, rd_b[31:0]},  64'h0);
        check("x2 untouched cfg1", {32'd0, rd_b[63:32]}, 64'h0);
        tick();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            we0 = $urandom_range(0, 1) == 1;
            we1 = $urandom_range(0, 1) == 1;
            wa0 = 5'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0 = $urandom;
            wd1 = $urandom;
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 2))
                    0:       ra[p*5 +: 5] = wa0;
                    1:       ra[p*5 +: 5] = wa1;
                    default: ra[p*5 +: 5] = 5'($urandom_range(0, 31));
                endcase
            end
            tick();
        end
        rst = 1'b0; idle();
        repeat (40) tick();
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(31 - a));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rfile_mp
`default_nettype wire
